// File: rtl/eth_pkg.sv
// Shared constants for the Ethernet receive path.
// RMII width, deserializer state encodings and sample divider presets.
package eth_pkg;

    localparam int MII_WIDTH = 2;

    localparam logic [1:0] RX_IDLE   = 2'h0;
    localparam logic [1:0] RX_ACTIVE = 2'h1;
    localparam logic [1:0] RX_DRAIN  = 2'h2;

    localparam int SAMPLE_DIV_100M = 1;
    localparam int SAMPLE_DIV_10M  = 10;

endpackage

// File: rtl/eth_rx_deser_if.sv
// Byte-stream bundle between the RMII deserializer and the receive control FSM.
// The deserializer uses master; the control FSM side uses slave.
interface eth_rx_deser_if #(
    parameter int pCNT_WIDTH = 16
);
    import eth_pkg::*;

    logic                  Rx_En;
    logic                  Crs_Dv;
    logic [MII_WIDTH-1:0]  Rxd;
    logic                  Byte_Rdy;
    logic [7:0]            Byte;
    logic                  Frame_Active;
    logic                  Frame_Done;
    logic [pCNT_WIDTH-1:0] Frame_Bytes;
    logic                  Dibit_Err;

    modport master (
        input  Rx_En, Crs_Dv, Rxd,
        output Byte_Rdy, Byte, Frame_Active,
        output Frame_Done, Frame_Bytes, Dibit_Err
    );

    modport slave (
        output Rx_En, Crs_Dv, Rxd,
        input  Byte_Rdy, Byte, Frame_Active,
        input  Frame_Done, Frame_Bytes, Dibit_Err
    );

endinterface

// File: rtl/eth_rx_sample_div.sv
// Dibit sample-point divider: strobes whenever the counter sits at zero.
// Clearing holds the counter at zero so the first active cycle samples.
module eth_rx_sample_div #(
    parameter int pSAMPLE_DIV = 1
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic clr,
    output logic sample
);

    localparam int W = (pSAMPLE_DIV > 1) ? $clog2(pSAMPLE_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(pSAMPLE_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample = (cnt_q == '0);

endmodule

// File: rtl/eth_rx_deser.sv
// RMII receive deserializer: packs post-SFD dibits into bytes while Rx_En
// is high, and reports frame end, partial-byte errors and byte count.
module eth_rx_deser
    import eth_pkg::*;
#(
    parameter int pMII_WIDTH  = MII_WIDTH,
    parameter int pSAMPLE_DIV = SAMPLE_DIV_100M,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic Clk,
    input  logic Rst_n,
    eth_rx_deser_if.master rx
);

    logic [1:0]            state_q, state_d;
    logic [7:0]            shift_q, shift_d;
    logic [1:0]            dcnt_q, dcnt_d;
    logic [pCNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic                  byte_rdy_q, byte_rdy_d;
    logic [7:0]            byte_q, byte_d;
    logic                  done_q, done_d;
    logic [pCNT_WIDTH-1:0] fbytes_q, fbytes_d;
    logic                  derr_q, derr_d;

    logic       sample;
    logic       start;
    logic       end_frame;
    logic       div_clr;
    logic [7:0] shifted;

    assign start     = (state_q == RX_IDLE) && rx.Rx_En && rx.Crs_Dv;
    assign end_frame = !rx.Rx_En || (sample && !rx.Crs_Dv);
    assign div_clr   = (state_q != RX_ACTIVE) && !start;
    assign shifted   = {rx.Rxd, shift_q[7:pMII_WIDTH]};

    eth_rx_sample_div #(
        .pSAMPLE_DIV(pSAMPLE_DIV)
    ) u_div (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clr   (div_clr),
        .sample(sample)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        dcnt_d     = dcnt_q;
        bcnt_d     = bcnt_q;
        byte_rdy_d = 1'b0;
        byte_d     = byte_q;
        done_d     = 1'b0;
        fbytes_d   = fbytes_q;
        derr_d     = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (start) begin
                    state_d = RX_ACTIVE;
                    shift_d = shifted;
                    dcnt_d  = 2'd1;
                    bcnt_d  = '0;
                end
            end
            RX_ACTIVE: begin
                // Rx_En falling beats a coincident 4th dibit
                if (end_frame) begin
                    done_d   = 1'b1;
                    fbytes_d = bcnt_q;
                    derr_d   = (dcnt_q != 2'd0);
                    dcnt_d   = 2'd0;
                    state_d  = rx.Rx_En ? RX_DRAIN : RX_IDLE;
                end else if (sample) begin
                    shift_d = shifted;
                    dcnt_d  = dcnt_q + 2'd1;
                    if (dcnt_q == 2'd3) begin
                        byte_rdy_d = 1'b1;
                        byte_d     = shifted;
                        if (!(&bcnt_q)) begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            RX_DRAIN: begin
                if (!rx.Rx_En) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= RX_IDLE;
            shift_q    <= '0;
            dcnt_q     <= '0;
            bcnt_q     <= '0;
            byte_rdy_q <= 1'b0;
            byte_q     <= '0;
            done_q     <= 1'b0;
            fbytes_q   <= '0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            dcnt_q     <= dcnt_d;
            bcnt_q     <= bcnt_d;
            byte_rdy_q <= byte_rdy_d;
            byte_q     <= byte_d;
            done_q     <= done_d;
            fbytes_q   <= fbytes_d;
            derr_q     <= derr_d;
        end
    end

    assign rx.Byte_Rdy     = byte_rdy_q;
    assign rx.Byte         = byte_q;
    assign rx.Frame_Active = (state_q == RX_ACTIVE);
    assign rx.Frame_Done   = done_q;
    assign rx.Frame_Bytes  = fbytes_q;
    assign rx.Dibit_Err    = derr_q;

endmodule

// File: doc/eth_rx_deser.md
Name: eth_rx_deser

Overview:
- RMII receive deserializer.
- Sits directly upstream of the receive control FSM.
- While the control FSM holds Rx_En high, it converts the post-SFD RMII dibit stream into bytes and presents each one with a single-cycle Byte_Rdy strobe.
- Also detects carrier loss, flags frames that end mid-byte, and reports a per-frame byte count.

Parameters:
- pMII_WIDTH, 2: RMII data width; fixed; only 2 is supported.
- pSAMPLE_DIV, 1: clock cycles per dibit; 1 = 100 Mb/s at 50 MHz, 10 = 10 Mb/s.
- pCNT_WIDTH, 16: width of the byte counter and Frame_Bytes.

Ports:
- Clk  in  1  50 MHz RMII reference clock.
- Rst_n  in  1  reset; asynchronous assert, active-low.
- Rx_En  in  1  from the control FSM; high from the first dibit after the SFD until the frame is done.
- Crs_Dv  in  1  RMII carrier sense / data valid.
- Rxd  in  2  RMII receive dibit; LSB-first within each byte.
- Byte_Rdy  out  1  one-cycle strobe; Byte is valid in that cycle.
- Byte  out  8  assembled byte.
- Frame_Active  out  1  high while in ACTIVE.
- Frame_Done  out  1  one-cycle strobe when a frame ends.
- Frame_Bytes  out  pCNT_WIDTH  bytes in the last frame; valid from Frame_Done until the next Frame_Done.
- Dibit_Err  out  1  one-cycle strobe, coincident with Frame_Done, when the frame ended with a partial byte.

Behaviour:
- Reset values: Byte_Rdy=0, Byte=0, Frame_Active=0, Frame_Done=0, Frame_Bytes=0, Dibit_Err=0. The FSM is in IDLE and all counters are 0.
- Reset mid-frame: the frame is abandoned immediately; no strobes fire after reset release.
- Sample strobe: the divider counts 0..pSAMPLE_DIV-1. It is cleared on IDLE->ACTIVE, so the sample point is the entry cycle and then every pSAMPLE_DIV cycles. With pSAMPLE_DIV=1 every ACTIVE cycle is a sample point.
- FSM states:
  - IDLE: when Rx_En=1 and Crs_Dv=1, go to ACTIVE. The dibit on Rxd in that same cycle is data dibit 0 and is captured.
  - ACTIVE, sample point with Crs_Dv=1:
    - Shift Rxd into the shift register at bits [7:6] and shift right by 2, so the first dibit ends in [1:0].
    - Increment the 2-bit dibit counter.
    - When the counter wraps 3->0, register the byte: Byte_Rdy=1 and Byte=assembled value on the next cycle (latency 1 cycle after the 4th dibit), and increment the byte counter. The byte counter saturates at all-ones.
  - ACTIVE, sample point with Crs_Dv=0, or any cycle with Rx_En=0:
    - End of frame.
    - Next cycle: Frame_Done=1, Frame_Bytes=byte counter.
    - Dibit_Err=1 if the dibit counter is nonzero. The partial byte is discarded and no Byte_Rdy is issued for it.
    - If Rx_En is still 1, go to DRAIN; otherwise go to IDLE.
  - DRAIN: wait for Rx_En=0, then go to IDLE. No outputs other than Frame_Done/Dibit_Err (from the transition) are driven.
- Simultaneous events: the 4th dibit is on a sample point and the end condition is Rx_En falling in the same cycle → Rx_En=0 wins; the dibit is not captured and the frame is ended with Dibit_Err=1.
- Frame_Done never coincides with the Byte_Rdy of the last byte. The last Byte_Rdy precedes it by at least 1 cycle.
- Byte is held between strobes.
- Frame_Bytes holds its value until the next frame end.

Decomposition:
- Shared package (eth_pkg): pMII_WIDTH, the RX deser state encodings (IDLE=2'h0, ACTIVE=2'h1, DRAIN=2'h2), pSAMPLE_DIV defaults for 10 and 100 Mb/s.
- One natural sub-module: eth_rx_sample_div, the divider counter that produces the sample strobe, with a clear input.

Test Plan:
- Nominal 100 Mb/s: pSAMPLE_DIV=1; Rx_En rises; dibits 01,10,11,00 then 11,11,00,00 (LSB-first), Crs_Dv=1 throughout, then Crs_Dv drops.
  - Byte_Rdy pulses with Byte=0x39, then 0x0F.
  - Frame_Done with Frame_Bytes=2, Dibit_Err=0.
- 64-byte frame, incrementing pattern 0x00..0x3F: 64 Byte_Rdy strobes exactly 4 cycles apart, values in order, Frame_Bytes=64.
- Partial byte: 5 bytes plus 2 extra dibits, then Crs_Dv=0.
  - 5 Byte_Rdy strobes.
  - Frame_Done and Dibit_Err in the same cycle; Frame_Bytes=5.
  - Next state DRAIN until Rx_En falls.
- 10 Mb/s: pSAMPLE_DIV=10; each dibit held for 10 cycles; bytes 0xAA, 0x55.
  - Byte_Rdy strobes 40 cycles apart with correct values.
  - No extra strobes between sample points.
- Asynchronous reset mid-byte: Rst_n low for 1 cycle after 2 dibits of byte 3.
  - All outputs 0 immediately.
  - No Byte_Rdy/Frame_Done until the next Rx_En rise.
  - The next frame assembles correctly from dibit 0.
- Rx_En falls on the cycle of the 4th dibit of byte 4 with Crs_Dv=1: no Byte_Rdy for byte 4, Frame_Done=1, Frame_Bytes=3, Dibit_Err=1, next state IDLE.
